audio_dac_serializer: RTL
=========================

# audio_dac_serializer

Parametrised stereo serializer driving the audio codec's DAC data line. The codec is bit-clock and LR-clock master; this block samples `bclk`/`daclrc` in the system clock domain, buffers one stereo sample from the sound source over a valid/ready handshake, and shifts it out MSB-first in I2S or left-justified format. It replaces the fixed 16-bit, LSB-first, unbuffered transmitter and adds configurable width, format, and underrun handling.

## Interface
- `DATA_WIDTH`, 16: bits per channel sample, 8..32.
- `I2S_MODE`, 1: 1 = I2S (MSB one `bclk` after the LR edge); 0 = left-justified (MSB on the LR edge).
- `UNDERRUN_ZERO`, 1: on underrun, 1 = send zeros; 0 = repeat the last frame.
- `clk` in 1: system clock; must be at least 8× the `bclk` frequency.
- `reset` in 1: reset, synchronous, active-high.
- `bclk` in 1: codec bit clock; asynchronous.
- `daclrc` in 1: codec DAC LR clock; asynchronous; 0 = left, 1 = right.
- `data_left` in DATA_WIDTH: left sample, two's complement.
- `data_right` in DATA_WIDTH: right sample.
- `in_valid` in 1: source presents a sample pair.
- `in_ready` out 1: holding buffer empty.
- `dacdat` out 1: serial data to the codec.
- `frame_start` out 1: one-`clk` pulse when a frame is loaded into the shifter.
- `underrun` out 1: one-`clk` pulse when a frame starts with the buffer empty.
- `underrun_count` out 16: saturating count of underruns.

## Operation
- **Synchronisers**
  - `bclk` and `daclrc` each pass through a 2-FF synchroniser, then one history FF.
  - A `bclk` falling edge (`fall`) is synchronised previous 1, current 0.
  - All shifter activity happens only on `fall` cycles. `daclrc` is sampled on `fall`.
- **Holding buffer**
  - One entry: `{left, right}` plus a `full` flag.
  - `in_ready = ~full & ~reset`.
  - Accept when `in_valid & in_ready`; `full` <= 1.
- **Channel start**
  - A `fall` where the sampled `daclrc` differs from its value at the previous `fall`.
- **Left start** (`daclrc` 1→0) loads a frame:
  - If `full`: shift registers <= buffer, `full` <= 0.
  - Otherwise: shift registers <= 0 (UNDERRUN_ZERO=1) or keep the last loaded frame (UNDERRUN_ZERO=0). Pulse `underrun`; `underrun_count` += 1, saturating at 0xFFFF.
  - Pulse `frame_start` on every load.
- **Load and accept in the same cycle**
  - When a load and an accept coincide (buffer empty), the load sees empty and underruns.
  - The accepted pair stays buffered for the next frame. There is no bypass path.
- **Bit counter** (width ⌈log2(DATA_WIDTH+2)⌉)
  - Cleared at each channel start.
  - Increments per `fall`, saturating at DATA_WIDTH+1.
- **Bit index**
  - k = counter − I2S_MODE, where the counter value is the one *after* the clear at channel start.
  - For 0 ≤ k < DATA_WIDTH, `dacdat` <= bit [DATA_WIDTH−1−k] of the current channel. Otherwise `dacdat` <= 0.
  - Extra slot bits beyond DATA_WIDTH are therefore 0.
- **Channel selection**
  - Left word when `daclrc` = 0, right word when `daclrc` = 1.
  - The right word comes from the same frame loaded at the preceding left start.
- **Start-up and reset**
  - After reset, `dacdat` holds 0 until the first left start.
  - A right start with no prior left start outputs zeros.
  - Reset mid-frame aborts the frame immediately. No partial word resumes; output restarts at the next left start.

## Timing
- Reset values: `dacdat` 0, `in_ready` 0 while `reset` = 1, and 1 in the first cycle after. `frame_start` 0, `underrun` 0, `underrun_count` 0, `full` 0. Shift registers, counter, and LR history are all 0.
- Pin-to-`fall` latency is 3 `clk`. `dacdat` updates on the `clk` edge ending the `fall` cycle, 4 `clk` after the pin falling edge at most.
- With `clk` ≥ 8× `bclk`, `dacdat` is stable well before the codec samples on the `bclk` rising edge.
- `frame_start` and `underrun` are asserted in the same cycle the load happens.
- `in_ready` drops the cycle after an accept. It rises the cycle after the load that empties the buffer.
- Data input is sampled only on an accept cycle. `data_*` changes while `in_ready` = 0 are ignored.

## Test plan
- **Basic I2S frame.** DATA_WIDTH=16, I2S_MODE=1, 32 `bclk` per channel, `clk`=16×`bclk`; preload L=0xA5C3, R=0x0F01.
  - Left slot: bit 0 = 0, bits 1..16 = 1010010111000011, rest 0.
  - Right slot: 0000111100000001 starting at its second bit.
- **Left-justified, 24-bit.** DATA_WIDTH=24, I2S_MODE=0, L=0x800001.
  - MSB 1 on the first left `fall`, bit 23 = 1, bits 24..31 = 0.
- **Underrun.** No `in_valid` before a left start.
  - UNDERRUN_ZERO=1: all-zero frame, `underrun` pulses once, `underrun_count` = 1.
  - UNDERRUN_ZERO=0: the previous frame repeats.
- **Simultaneous accept and load.** Assert `in_valid` in the exact load cycle with the buffer empty.
  - `underrun` = 1, the pair is accepted, and it appears in the next frame.
- **Handshake.** Hold `in_valid` continuously.
  - Exactly one accept per frame; `in_ready` = 0 between accept and load.
  - Data changed while `in_ready` = 0 never appears on `dacdat`.
- **Reset mid-frame.** Assert `reset` at left bit 5 for 2 cycles.
  - `dacdat` = 0 and `in_ready` = 0 during reset.
  - `dacdat` stays 0 through the remaining right slot; the next left start outputs the newly buffered frame.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: stereo I2S / left-justified DAC data serializer.
// The codec owns bclk and daclrc; both are synchronised into clk and all
// serial activity happens on the clk cycle that sees a synchronised bclk
// falling edge. One stereo sample pair is buffered ahead of the frame.
module audio_dac_serializer #(
    parameter int DATA_WIDTH    = 16,
    parameter int I2S_MODE      = 1,
    parameter int UNDERRUN_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bclk,
    input  logic                  daclrc,
    input  logic [DATA_WIDTH-1:0] data_left,
    input  logic [DATA_WIDTH-1:0] data_right,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  dacdat,
    output logic                  frame_start,
    output logic                  underrun,
    output logic [15:0]           underrun_count
);

    // Counter must reach DATA_WIDTH+1 so the slot tail reads as out of range.
    localparam int             CW      = $clog2(DATA_WIDTH + 2);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DATA_WIDTH + 1);
    localparam logic [CW-1:0]  CNT_DW  = CW'(DATA_WIDTH);

    logic                  bclk_s1, bclk_s2, bclk_h;
    logic                  lrc_s1, lrc_s2;
    logic                  lr_prev;
    logic                  full;
    logic [DATA_WIDTH-1:0] buf_left, buf_right;
    logic [DATA_WIDTH-1:0] sh_left, sh_right;
    logic [CW-1:0]         cnt;

    logic                  fall, lr_now, ch_start, load, accept;
    logic [CW-1:0]         cnt_nxt, idx;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] left_nxt, right_nxt, word_sel, shifted;
    logic                  dac_nxt;

    assign in_ready = ~full & ~reset;
    assign accept   = in_valid & in_ready;

    // Two-stage synchronisers for both codec clocks plus a bclk history stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_h  <= 1'b0;
            lrc_s1  <= 1'b0;
            lrc_s2  <= 1'b0;
        end else begin
            bclk_s1 <= bclk;
            bclk_s2 <= bclk_s1;
            bclk_h  <= bclk_s2;
            lrc_s1  <= daclrc;
            lrc_s2  <= lrc_s1;
        end
    end

    // Edge detect, frame load selection and next serial bit.
    always_comb begin
        fall     = bclk_h & ~bclk_s2;
        lr_now   = lrc_s2;
        ch_start = fall && (lr_now != lr_prev);
        load     = ch_start && !lr_now;

        // A load with an empty buffer either zeroes or repeats the frame.
        left_nxt  = sh_left;
        right_nxt = sh_right;
        if (load) begin
            if (full) begin
                left_nxt  = buf_left;
                right_nxt = buf_right;
            end else if (UNDERRUN_ZERO != 0) begin
                left_nxt  = '0;
                right_nxt = '0;
            end
        end

        cnt_nxt = cnt;
        if (ch_start)
            cnt_nxt = '0;
        else if (cnt != CNT_MAX)
            cnt_nxt = cnt + CW'(1);

        // I2S delays the MSB by one bclk, so count 0 is a dead slot.
        if (I2S_MODE != 0) begin
            idx      = cnt_nxt - CW'(1);
            in_range = (cnt_nxt != '0) && (idx < CNT_DW);
        end else begin
            idx      = cnt_nxt;
            in_range = cnt_nxt < CNT_DW;
        end

        word_sel = lr_now ? right_nxt : left_nxt;
        shifted  = word_sel << idx;
        dac_nxt  = in_range ? shifted[DATA_WIDTH-1] : 1'b0;
    end

    // Holding buffer, frame shifter, bit counter and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            full           <= 1'b0;
            buf_left       <= '0;
            buf_right      <= '0;
            sh_left        <= '0;
            sh_right       <= '0;
            cnt            <= '0;
            lr_prev        <= 1'b0;
            dacdat         <= 1'b0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= 16'd0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            // Accept only happens while empty, load only clears while full,
            // so the two never fight over the flag.
            if (accept) begin
                buf_left  <= data_left;
                buf_right <= data_right;
                full      <= 1'b1;
            end

            if (fall) begin
                lr_prev <= lr_now;
                cnt     <= cnt_nxt;
                dacdat  <= dac_nxt;
                if (load) begin
                    sh_left     <= left_nxt;
                    sh_right    <= right_nxt;
                    frame_start <= 1'b1;
                    if (full) begin
                        full <= 1'b0;
                    end else begin
                        underrun <= 1'b1;
                        if (underrun_count != 16'hFFFF)
                            underrun_count <= underrun_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule
